// File: rtl/key_move_queue.sv
// PS/2 scan-code to snake-direction decoder with a small move queue.
// Accepted moves are buffered and popped one per game tick via consume.
module key_move_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter logic [1:0]  INIT_MOVE     = 2'd0,
  parameter bit          BLOCK_REVERSE = 1'b1,
  parameter bit          ENABLE_WASD   = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      newKey,
  input  logic [7:0]                keyCode,
  input  logic                      consume,
  output logic [1:0]                move,
  output logic                      pending,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCount = CntW'(DEPTH);

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBreak = 8'hF0;

  localparam logic [1:0] DirRight = 2'd0;
  localparam logic [1:0] DirUp    = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirDown  = 2'd3;

  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      move_q, move_d;
  logic            pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      mem_q [DEPTH];

  logic            is_prefix;
  logic            key_event;
  logic            cand_valid;
  logic [1:0]      cand_dir;
  logic [1:0]      ref_dir;
  logic            is_same;
  logic            is_reverse;
  logic            accept;
  logic            pop;
  logic            full;
  logic            push;

  assign is_prefix = (keyCode == CodeExt) || (keyCode == CodeBreak);
  // Only a non-prefix byte outside a break sequence is a key press to decode.
  assign key_event = newKey && !is_prefix && !brk_q;

  always_comb begin
    cand_valid = 1'b0;
    cand_dir   = DirRight;
    case (keyCode)
      8'h74: begin cand_valid = 1'b1; cand_dir = DirRight; end
      8'h75: begin cand_valid = 1'b1; cand_dir = DirUp;    end
      8'h6B: begin cand_valid = 1'b1; cand_dir = DirLeft;  end
      8'h72: begin cand_valid = 1'b1; cand_dir = DirDown;  end
      8'h23: begin cand_valid = ENABLE_WASD && !ext_q; cand_dir = DirRight; end
      8'h1D: begin cand_valid = ENABLE_WASD && !ext_q; cand_dir = DirUp;    end
      8'h1C: begin cand_valid = ENABLE_WASD && !ext_q; cand_dir = DirLeft;  end
      8'h1B: begin cand_valid = ENABLE_WASD && !ext_q; cand_dir = DirDown;  end
      default: begin
        cand_valid = 1'b0;
        cand_dir   = DirRight;
      end
    endcase
  end

  // Filter against the most recent intent: the queue tail, or the committed move.
  assign ref_dir    = (count_q != '0) ? mem_q[wr_ptr_q - PtrW'(1)] : move_q;
  assign is_same    = (cand_dir == ref_dir);
  assign is_reverse = BLOCK_REVERSE && (cand_dir == (ref_dir ^ 2'b10));
  assign accept     = key_event && cand_valid && !is_same && !is_reverse;

  assign pop  = consume && (count_q != '0);
  assign full = (count_q == DepthCount);
  // A pop in the same cycle frees a slot, so a full queue can still take the push.
  assign push = accept && (!full || pop);

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    move_d     = move_q;
    overflow_d = overflow_q;

    if (newKey) begin
      if (keyCode == CodeExt) begin
        ext_d = 1'b1;
      end else if (keyCode == CodeBreak) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    if (pop) begin
      move_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (accept && full && !pop) begin
      overflow_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    pending_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      move_q     <= INIT_MOVE;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      move_q     <= move_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= cand_dir;
    end
  end

  assign move     = move_q;
  assign pending  = pending_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_move_queue.sv
// Randomised bench for key_move_queue: a queue-based reference model predicts
// the registered outputs after every clock; a monitor compares them.
module tb_key_move_queue;

  localparam int unsigned DEPTH         = 4;
  localparam logic [1:0]  INIT_MOVE     = 2'd0;
  localparam bit          BLOCK_REVERSE = 1'b1;
  localparam bit          ENABLE_WASD   = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       newKey = 1'b0;
  logic [7:0] keyCode = 8'h00;
  logic       consume = 1'b0;
  logic [1:0] move;
  logic       pending;
  logic [$clog2(DEPTH):0] count;
  logic       overflow;

  always #5 clk = ~clk;

  key_move_queue #(
    .DEPTH(DEPTH),
    .INIT_MOVE(INIT_MOVE),
    .BLOCK_REVERSE(BLOCK_REVERSE),
    .ENABLE_WASD(ENABLE_WASD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .newKey(newKey),
    .keyCode(keyCode),
    .consume(consume),
    .move(move),
    .pending(pending),
    .count(count),
    .overflow(overflow)
  );

  typedef struct {
    int unsigned mv;
    int unsigned cnt;
    int unsigned pend;
    int unsigned ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int unsigned mq[$];
  int unsigned m_move = INIT_MOVE;
  bit          m_ovf  = 1'b0;
  bit          m_ext  = 1'b0;
  bit          m_brk  = 1'b0;

  function automatic void model_step(bit rst, bit nk, logic [7:0] kc, bit cons);
    int unsigned refd;
    int unsigned c;
    int unsigned n;
    bit          cv;
    bit          pop;
    bit          acc;
    exp_t        e;
    c  = 0;
    cv = 1'b0;
    if (rst) begin
      mq.delete();
      m_move = INIT_MOVE;
      m_ovf  = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else begin
      n    = mq.size();
      refd = (n > 0) ? mq[n-1] : m_move;
      pop  = cons && (n > 0);
      if (nk) begin
        if (kc == 8'hE0) m_ext = 1'b1;
        else if (kc == 8'hF0) m_brk = 1'b1;
        else begin
          if (!m_brk) begin
            case (kc)
              8'h74: begin cv = 1'b1; c = 0; end
              8'h75: begin cv = 1'b1; c = 1; end
              8'h6B: begin cv = 1'b1; c = 2; end
              8'h72: begin cv = 1'b1; c = 3; end
              8'h23: begin cv = ENABLE_WASD && !m_ext; c = 0; end
              8'h1D: begin cv = ENABLE_WASD && !m_ext; c = 1; end
              8'h1C: begin cv = ENABLE_WASD && !m_ext; c = 2; end
              8'h1B: begin cv = ENABLE_WASD && !m_ext; c = 3; end
              default: cv = 1'b0;
            endcase
          end
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      acc = cv && (c != refd) && !(BLOCK_REVERSE && (c == (refd ^ 2)));
      if (pop) m_move = mq.pop_front();
      if (acc) begin
        if (n < DEPTH || pop) mq.push_back(c);
        else m_ovf = 1'b1;
      end
    end
    e.mv   = m_move;
    e.cnt  = mq.size();
    e.pend = (mq.size() > 0) ? 1 : 0;
    e.ovf  = m_ovf;
    sb.push_back(e);
  endfunction

  task automatic step(bit rst, bit nk, logic [7:0] kc, bit cons);
    @(negedge clk);
    reset   = rst;
    newKey  = nk;
    keyCode = kc;
    consume = cons;
    @(posedge clk);
    #1;
    model_step(rst, nk, kc, cons);
  endtask

  task automatic key(logic [7:0] kc);
    step(1'b0, 1'b1, kc, 1'b0);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every clock produces a registered result; compare it on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("move",     32'(move),     32'(e.mv));
      chk("count",    32'(count),    32'(e.cnt));
      chk("pending",  32'(pending),  32'(e.pend));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  logic [7:0] codes [12];

  initial begin
    codes = '{8'hE0, 8'hF0, 8'h74, 8'h75, 8'h6B, 8'h72,
              8'h74, 8'h75, 8'h6B, 8'h72, 8'h1C, 8'h23};

    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Press up, then pop it
    key(8'h75);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Extended press and release of right
    key(8'hE0); key(8'h74); key(8'hE0); key(8'hF0); key(8'h74);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Filter: reverse, duplicate, accept, reverse of queued tail
    key(8'h6B); key(8'h74); key(8'h72); key(8'h75);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill, overflow, then push together with pop at full
    step(1'b1, 1'b0, 8'h00, 1'b0);
    key(8'h75); key(8'h6B); key(8'h72); key(8'h74);
    key(8'h75);
    step(1'b0, 1'b1, 8'h75, 1'b1);

    // Drain, consume on empty, unmapped code
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    key(8'h1C);

    // Reset in the middle of a break sequence
    key(8'hF0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    key(8'h74);
    key(8'h75);
    key(8'hE0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    key(8'h72);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] kc;
      bit nk;
      bit cons;
      bit rst;
      kc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 11)];
      nk   = ($urandom_range(0, 2) != 0);
      cons = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step(rst, nk, kc, cons);
    end

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_move_queue.md
Name: key_move_queue

Overview:
- Parametrised successor to the single-register key-to-direction decoder in the snake game's input path.
- Parses the PS/2 scan-code stream from the keyboard receiver:
  - E0 extended prefix.
  - F0 break prefix.
  - Arrow keys, plus optional WASD.
- Filters out same-direction and reversal moves, then buffers accepted moves in a small FIFO.
- The game-tick logic pops one move per tick, so fast key sequences are kept and spread over successive ticks instead of being lost.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- INIT_MOVE, 0, direction loaded into move on reset (0 right, 1 up, 2 left, 3 down).
- BLOCK_REVERSE, 1, 1 = reject a candidate opposite to the reference direction.
- ENABLE_WASD, 0, 1 = also accept W/A/S/D codes.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- newKey  input  1  one-cycle strobe: keyCode valid this cycle.
- keyCode  input  8  scan-code byte from the PS/2 receiver.
- consume  input  1  one-cycle strobe from the game tick: pop next move.
- move  output  2  current committed direction (registered).
- pending  output  1  queue non-empty (registered).
- count  output  $clog2(DEPTH)+1  entries queued (registered).
- overflow  output  1  sticky: a valid move was dropped because the queue was full.

Behaviour:
- Reset values:
  - move = INIT_MOVE.
  - count = 0, pending = 0, overflow = 0.
  - Prefix flags ext = 0, brk = 0.
  - Queue pointers = 0.
- Parser: acts only when newKey = 1; otherwise holds state.
  - 0xE0: set ext; nothing else happens.
  - 0xF0: set brk; nothing else happens.
  - Any other byte with brk = 1: discard the byte (key release), clear brk and ext.
  - Any other byte with brk = 0 is decoded, then ext is cleared:
    - Arrows, accepted with or without E0: 0x74 = right, 0x75 = up, 0x6B = left, 0x72 = down.
    - If ENABLE_WASD = 1 and ext = 0: 0x23 = right, 0x1D = up, 0x1C = left, 0x1B = down.
    - WASD codes with ext = 1 are not moves.
    - Any unmapped byte is a non-move: no push, flags cleared.
- Reference direction = last queued entry if count > 0, else move.
- Candidate filter, applied to a decoded move c:
  - Reject if c equals the reference direction.
  - If BLOCK_REVERSE = 1, also reject if c equals reference XOR 2'b10.
  - A rejected candidate changes nothing and does not set overflow.
- Push: an accepted candidate is written at the tail; count increments next cycle.
  - newKey → count/pending update latency is 1 cycle.
- Pop: on consume with count > 0:
  - move <= head; head advances; count decrements next cycle.
  - consume → move latency is 1 cycle.
  - consume with count = 0: no effect; move holds.
- Simultaneous push and pop in the same cycle:
  - Both happen; count is unchanged.
  - Reference direction is evaluated on pre-cycle state.
  - At count = DEPTH, the push is accepted because a slot frees this cycle.
- Full: at count = DEPTH with no simultaneous pop, an accepted candidate is dropped and overflow is set.
  - overflow clears only on reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count saturates logically at DEPTH.
- Reset mid-sequence:
  - Pending prefixes are discarded and the queue is emptied.
  - A byte following a pre-reset E0/F0 is decoded as a fresh code.
- Outputs are glitch-free registers only; no combinational path from inputs to outputs.

Test Plan:
1. Reset, INIT_MOVE = 0; newKey with 0x75 (up) → next cycle count = 1, pending = 1; consume → next cycle move = 1, count = 0.
2. Stream E0 74, E0 F0 74 (press then release right) with move = 1 → exactly one entry queued (right); the release adds nothing; ext/brk clear afterwards.
3. move = 0 (right), count = 0; send 0x6B (left) → rejected, count = 0. Send 0x74 → rejected as duplicate. Send 0x72 → accepted. Then send 0x75 → rejected, since it reverses down.
4. DEPTH = 4: push up, left, down, right → count = 4. A fifth valid move (up) → dropped, overflow = 1. Same fifth move pushed together with consume → accepted, count stays 4, move = head.
5. consume pulses with count = 0 → move unchanged, count = 0. Unmapped code 0x1C with ENABLE_WASD = 0 → no push.
6. Send 0xF0, assert reset for one cycle, then send 0x74 → after reset move = INIT_MOVE, overflow = 0; 0x74 is treated as a press and queued if it passes the filter.
